// File: rtl/dmem_shadow_monitor_if.sv
// Unified valid/ready memory bus between a core-side harness (master) and the monitor (slave).
// The harness also supplies mem_rdata from its memory model.
interface dmem_shadow_monitor_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  localparam int NB = DW / 8;

  logic          mem_valid;
  logic          mem_instr;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [NB-1:0] mem_wstrb;
  logic [DW-1:0] mem_rdata;
  logic          mem_ready;

  modport master (
    output mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb, mem_rdata,
    input  mem_ready
  );

  modport slave (
    input  mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb, mem_rdata,
    output mem_ready
  );
endinterface

// File: rtl/dmem_shadow_monitor.sv
// Fixed-latency ready responder that shadows NTRACK word addresses with per-byte known bits
// and flags read-data mismatches and handshake-protocol violations (sticky until reset).
module dmem_shadow_monitor #(
  parameter int AW          = 32,
  parameter int DW          = 32,
  parameter int NTRACK      = 2,
  parameter int WAIT_CYCLES = 0,
  parameter int CHECK_INSTR = 0,
  localparam int NB  = DW / 8,
  localparam int OFS = (NB > 1) ? $clog2(NB) : 0,
  localparam int IW  = (NTRACK > 1) ? $clog2(NTRACK) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  dmem_shadow_monitor_if.slave bus,
  input  logic [NTRACK*AW-1:0] track_addr,
  output logic                 err_mismatch,
  output logic [IW-1:0]        mismatch_idx,
  output logic                 err_protocol,
  output logic [15:0]          txn_count
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} state_t;

  state_t        r_state;
  logic          r_ready;
  logic [7:0]    r_cnt;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_wdata;
  logic [NB-1:0] r_wstrb;
  logic          r_instr;
  logic [DW-1:0] r_shadow [NTRACK];
  logic [NB-1:0] r_known  [NTRACK];
  logic          r_err_mm;
  logic [IW-1:0] r_idx;
  logic          r_err_proto;
  logic [15:0]   r_txn;

  logic [NTRACK-1:0] w_match;
  logic [NTRACK-1:0] w_diff;
  logic              w_check;
  logic              w_req_diff;
  logic              w_any_diff;
  logic              w_found;
  logic [IW-1:0]     w_first;

  always_comb begin
    w_req_diff = !bus.mem_valid || (bus.mem_addr != r_addr) || (bus.mem_wdata != r_wdata) ||
                 (bus.mem_wstrb != r_wstrb) || (bus.mem_instr != r_instr);
    w_check    = (r_wstrb == '0) && (!r_instr || (CHECK_INSTR != 0));
    w_found    = 1'b0;
    w_first    = '0;
    for (int unsigned i = 0; i < NTRACK; i++) begin
      // XOR-then-shift compares word addresses while ignoring the byte offset
      w_match[i] = ((r_addr ^ track_addr[i*AW +: AW]) >> OFS) == '0;
      w_diff[i]  = 1'b0;
      for (int unsigned b = 0; b < NB; b++) begin
        if (r_known[i][b] && (bus.mem_rdata[b*8 +: 8] != r_shadow[i][b*8 +: 8]))
          w_diff[i] = 1'b1;
      end
      w_diff[i] = w_diff[i] && w_match[i] && w_check;
      if (w_diff[i] && !w_found) begin
        w_found = 1'b1;
        w_first = IW'(i);
      end
    end
    w_any_diff = |w_diff;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_ready     <= 1'b0;
      r_cnt       <= '0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_wstrb     <= '0;
      r_instr     <= 1'b0;
      r_err_mm    <= 1'b0;
      r_idx       <= '0;
      r_err_proto <= 1'b0;
      r_txn       <= '0;
      for (int unsigned i = 0; i < NTRACK; i++) begin
        r_shadow[i] <= '0;
        r_known[i]  <= '0;
      end
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.mem_valid) begin
            r_addr  <= bus.mem_addr;
            r_wdata <= bus.mem_wdata;
            r_wstrb <= bus.mem_wstrb;
            r_instr <= bus.mem_instr;
            if (WAIT_CYCLES == 0) begin
              r_state <= S_ACK;
              r_ready <= 1'b1;
            end else begin
              r_state <= S_WAIT;
              r_cnt   <= 8'(WAIT_CYCLES - 1);
            end
          end
        end
        S_WAIT: begin
          if (w_req_diff) r_err_proto <= 1'b1;
          if (r_cnt == '0) begin
            r_state <= S_ACK;
            r_ready <= 1'b1;
          end else begin
            r_cnt <= r_cnt - 8'd1;
          end
        end
        S_ACK: begin
          if (w_req_diff) r_err_proto <= 1'b1;
          r_state <= S_IDLE;
          r_ready <= 1'b0;
          if (r_txn != 16'hFFFF) r_txn <= r_txn + 16'd1;
          for (int unsigned i = 0; i < NTRACK; i++) begin
            for (int unsigned b = 0; b < NB; b++) begin
              if (w_match[i] && r_wstrb[b]) begin
                r_shadow[i][b*8 +: 8] <= r_wdata[b*8 +: 8];
                r_known[i][b]         <= 1'b1;
              end
            end
          end
          if (w_any_diff) begin
            r_err_mm <= 1'b1;
            if (!r_err_mm) r_idx <= w_first;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_ready <= 1'b0;
        end
      endcase
    end
  end

  assign bus.mem_ready = r_ready;
  assign err_mismatch  = r_err_mm;
  assign mismatch_idx  = r_idx;
  assign err_protocol  = r_err_proto;
  assign txn_count     = r_txn;

endmodule

// File: tb/tb_dmem_shadow_monitor.sv
// Bench for dmem_shadow_monitor: one instance with no wait states, one with three,
// both compared every cycle against a cycle-number/byte-array model of the monitor.
module tb_dmem_shadow_monitor;

  localparam int            CI    = 0;
  localparam logic [63:0]   TRACK = {32'h0000_0200, 32'h0000_0100};

  logic clk;
  logic rst;

  logic        b_valid [2];
  logic        b_instr [2];
  logic [31:0] b_addr  [2];
  logic [31:0] b_wdata [2];
  logic [3:0]  b_wstrb [2];
  logic [31:0] b_rdata [2];

  logic        w_ready [2];
  logic        w_errmm [2];
  logic [0:0]  w_idx   [2];
  logic        w_errp  [2];
  logic [15:0] w_txn   [2];

  int checks = 0;
  int errors = 0;

  dmem_shadow_monitor_if #(.AW(32), .DW(32)) bus0 ();
  dmem_shadow_monitor_if #(.AW(32), .DW(32)) bus1 ();

  assign bus0.mem_valid = b_valid[0];
  assign bus0.mem_instr = b_instr[0];
  assign bus0.mem_addr  = b_addr[0];
  assign bus0.mem_wdata = b_wdata[0];
  assign bus0.mem_wstrb = b_wstrb[0];
  assign bus0.mem_rdata = b_rdata[0];
  assign w_ready[0]     = bus0.mem_ready;
  assign bus1.mem_valid = b_valid[1];
  assign bus1.mem_instr = b_instr[1];
  assign bus1.mem_addr  = b_addr[1];
  assign bus1.mem_wdata = b_wdata[1];
  assign bus1.mem_wstrb = b_wstrb[1];
  assign bus1.mem_rdata = b_rdata[1];
  assign w_ready[1]     = bus1.mem_ready;

  dmem_shadow_monitor #(.AW(32), .DW(32), .NTRACK(2), .WAIT_CYCLES(0), .CHECK_INSTR(CI)) u0 (
    .clk(clk), .reset(rst), .bus(bus0), .track_addr(TRACK),
    .err_mismatch(w_errmm[0]), .mismatch_idx(w_idx[0]), .err_protocol(w_errp[0]), .txn_count(w_txn[0])
  );

  dmem_shadow_monitor #(.AW(32), .DW(32), .NTRACK(2), .WAIT_CYCLES(3), .CHECK_INSTR(CI)) u1 (
    .clk(clk), .reset(rst), .bus(bus1), .track_addr(TRACK),
    .err_mismatch(w_errmm[1]), .mismatch_idx(w_idx[1]), .err_protocol(w_errp[1]), .txn_count(w_txn[1])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- model: request timing by cycle number, shadow as byte arrays ----------------
  int unsigned ec;
  logic [31:0] trk    [2];
  logic        m_pend [2];
  int unsigned m_acc  [2];
  logic [31:0] m_ca   [2];
  logic [31:0] m_cw   [2];
  logic [3:0]  m_cs   [2];
  logic        m_ci   [2];
  logic        m_ready[2];
  logic        m_errmm[2];
  logic [0:0]  m_idx  [2];
  logic        m_errp [2];
  logic [15:0] m_txn  [2];
  logic [7:0]  m_sh   [2][2][4];
  logic        m_kn   [2][2][4];

  task automatic m_clear();
    trk[0] = TRACK[31:0];
    trk[1] = TRACK[63:32];
    for (int d = 0; d < 2; d++) begin
      m_pend[d] = 0; m_ready[d] = 0; m_errmm[d] = 0; m_idx[d] = 0; m_errp[d] = 0; m_txn[d] = 0;
      m_acc[d] = 0;
      for (int j = 0; j < 2; j++)
        for (int b = 0; b < 4; b++) begin
          m_sh[d][j][b] = 8'h00;
          m_kn[d][j][b] = 1'b0;
        end
    end
  endtask

  task automatic m_step(input int d, input int unsigned w);
    logic diff;
    if (m_pend[d]) begin
      if (!b_valid[d] || b_addr[d] != m_ca[d] || b_wdata[d] != m_cw[d] ||
          b_wstrb[d] != m_cs[d] || b_instr[d] != m_ci[d])
        m_errp[d] = 1'b1;
      if (ec == m_acc[d] + w + 1) begin
        for (int j = 0; j < 2; j++) begin
          if ((m_ca[d] >> 2) == (trk[j] >> 2)) begin
            if (m_cs[d] != 4'b0000) begin
              for (int b = 0; b < 4; b++)
                if (m_cs[d][b]) begin
                  m_sh[d][j][b] = m_cw[d][8*b +: 8];
                  m_kn[d][j][b] = 1'b1;
                end
            end else if (!m_ci[d] || CI != 0) begin
              diff = 1'b0;
              for (int b = 0; b < 4; b++)
                if (m_kn[d][j][b] && b_rdata[d][8*b +: 8] != m_sh[d][j][b]) diff = 1'b1;
              if (diff) begin
                if (!m_errmm[d]) m_idx[d] = 1'(j);
                m_errmm[d] = 1'b1;
              end
            end
          end
        end
        m_txn[d]  = (m_txn[d] == 16'hFFFF) ? 16'hFFFF : m_txn[d] + 16'd1;
        m_pend[d] = 1'b0;
      end
    end else if (b_valid[d]) begin
      m_pend[d] = 1'b1;
      m_acc[d]  = ec;
      m_ca[d] = b_addr[d]; m_cw[d] = b_wdata[d]; m_cs[d] = b_wstrb[d]; m_ci[d] = b_instr[d];
    end
    m_ready[d] = m_pend[d] && (ec == m_acc[d] + w);
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_clear();
    end else begin
      ec++;
      m_step(0, 0);
      m_step(1, 3);
    end
  end

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      cmp($sformatf("u%0d.mem_ready", d),    32'(w_ready[d]), 32'(m_ready[d]));
      cmp($sformatf("u%0d.err_mismatch", d), 32'(w_errmm[d]), 32'(m_errmm[d]));
      cmp($sformatf("u%0d.mismatch_idx", d), 32'(w_idx[d]),   32'(m_idx[d]));
      cmp($sformatf("u%0d.err_protocol", d), 32'(w_errp[d]),  32'(m_errp[d]));
      cmp($sformatf("u%0d.txn_count", d),    32'(w_txn[d]),   32'(m_txn[d]));
    end
  end

  // ---------------- stimulus ----------------
  task automatic idle_bus();
    for (int d = 0; d < 2; d++) begin
      b_valid[d] = 0; b_instr[d] = 0; b_addr[d] = '0; b_wdata[d] = '0; b_wstrb[d] = '0; b_rdata[d] = '0;
    end
  endtask

  task automatic wait_rdy(input int d, output int n);
    n = 0;
    while (w_ready[d] !== 1'b1 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    if (w_ready[d] !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL u%0d.ready_timeout actual=0 expected=1 t=%0t", d, $time);
    end
  endtask

  task automatic txn(input int d, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] st,
                     input logic [31:0] rd, input logic ins, input logic keep, output int lat);
    b_valid[d] = 1'b1; b_addr[d] = a; b_wdata[d] = wd; b_wstrb[d] = st; b_rdata[d] = rd; b_instr[d] = ins;
    wait_rdy(d, lat);
    @(posedge clk); #1;
    if (!keep) b_valid[d] = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_bus();
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  int lat;

  initial begin
    ec = 0;
    m_clear();
    idle_bus();
    rst = 1'b0;
    #2 rst = 1'b1;
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b0;
    cmp("reset.u0.txn", 32'(w_txn[0]), 32'd0);
    cmp("reset.u1.ready", 32'(w_ready[1]), 32'd0);

    // zero-wait instance: write/read, instruction fetch, partial write, back-to-back
    txn(0, 32'h100, 32'hDEADBEEF, 4'hF, 32'h0, 0, 0, lat);
    cmp("u0.write_latency", lat, 1);
    txn(0, 32'h100, 32'h0, 4'h0, 32'hDEADBEEF, 0, 0, lat);
    cmp("u0.match_read.err", 32'(w_errmm[0]), 32'd0);
    cmp("u0.match_read.txn", 32'(w_txn[0]), 32'd2);
    txn(0, 32'h100, 32'h0, 4'h0, 32'h0, 1, 0, lat);
    cmp("u0.ifetch_unchecked.err", 32'(w_errmm[0]), 32'd0);
    txn(0, 32'h202, 32'h0000ABCD, 4'b0011, 32'h0, 0, 0, lat);
    txn(0, 32'h200, 32'h0, 4'h0, 32'h1234ABCD, 0, 0, lat);
    cmp("u0.unknown_lanes.err", 32'(w_errmm[0]), 32'd0);
    cmp("u0.unknown_lanes.txn", 32'(w_txn[0]), 32'd5);
    txn(0, 32'h300, 32'h0, 4'h0, 32'h0, 0, 1, lat);
    txn(0, 32'h300, 32'h0, 4'h0, 32'h0, 0, 0, lat);
    cmp("u0.b2b_latency", lat, 1);
    cmp("u0.b2b_txn", 32'(w_txn[0]), 32'd7);
    txn(0, 32'h200, 32'h0, 4'h0, 32'h1234ABCE, 0, 0, lat);
    cmp("u0.mismatch1.err", 32'(w_errmm[0]), 32'd1);
    cmp("u0.mismatch1.idx", 32'(w_idx[0]), 32'd1);
    cmp("u0.protocol_clean", 32'(w_errp[0]), 32'd0);

    do_reset();
    cmp("u0.after_reset.err", 32'(w_errmm[0]), 32'd0);
    txn(0, 32'h100, 32'hDEADBEEF, 4'hF, 32'h0, 0, 0, lat);
    txn(0, 32'h100, 32'h0, 4'h0, 32'hDEADBEEE, 0, 0, lat);
    cmp("u0.mismatch0.err", 32'(w_errmm[0]), 32'd1);
    cmp("u0.mismatch0.idx", 32'(w_idx[0]), 32'd0);
    txn(0, 32'h200, 32'h11223344, 4'hF, 32'h0, 0, 0, lat);
    txn(0, 32'h203, 32'h0, 4'h0, 32'h0, 0, 0, lat);
    cmp("u0.idx_held", 32'(w_idx[0]), 32'd0);
    cmp("u0.idx_held.txn", 32'(w_txn[0]), 32'd4);

    // three-wait instance: latency, protocol violations, reset mid-wait
    do_reset();
    txn(1, 32'h100, 32'h0, 4'h0, 32'h0, 0, 0, lat);
    cmp("u1.latency", lat, 4);
    txn(1, 32'h104, 32'h0, 4'h0, 32'h0, 0, 0, lat);
    cmp("u1.latency2", lat, 4);
    cmp("u1.clean.errp", 32'(w_errp[1]), 32'd0);
    txn(1, 32'h200, 32'h00FF0000, 4'b0100, 32'h0, 0, 0, lat);
    txn(1, 32'h201, 32'h0, 4'h0, 32'h00FE0000, 0, 0, lat);
    cmp("u1.mismatch.idx", 32'(w_idx[1]), 32'd1);
    cmp("u1.mismatch.txn", 32'(w_txn[1]), 32'd4);

    b_valid[1] = 1'b1; b_addr[1] = 32'h300; b_wstrb[1] = 4'h0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    b_valid[1] = 1'b0;
    wait_rdy(1, lat);
    @(posedge clk); #1;
    cmp("u1.drop.errp", 32'(w_errp[1]), 32'd1);
    cmp("u1.drop.txn", 32'(w_txn[1]), 32'd5);

    do_reset();
    cmp("u1.reset.errp", 32'(w_errp[1]), 32'd0);
    b_valid[1] = 1'b1; b_addr[1] = 32'h300;
    @(posedge clk); #1;
    @(posedge clk); #1;
    b_addr[1] = 32'h304;
    wait_rdy(1, lat);
    @(posedge clk); #1;
    b_valid[1] = 1'b0;
    cmp("u1.addr_change.errp", 32'(w_errp[1]), 32'd1);
    cmp("u1.addr_change.txn", 32'(w_txn[1]), 32'd1);

    do_reset();
    txn(1, 32'h100, 32'hCAFEF00D, 4'hF, 32'h0, 0, 0, lat);
    b_valid[1] = 1'b1; b_addr[1] = 32'h100; b_wstrb[1] = 4'h0; b_rdata[1] = 32'h0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    idle_bus();
    #1;
    cmp("u1.reset_mid_wait.ready", 32'(w_ready[1]), 32'd0);
    cmp("u1.reset_mid_wait.txn", 32'(w_txn[1]), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    cmp("u1.idle_after_reset.ready", 32'(w_ready[1]), 32'd0);
    txn(1, 32'h100, 32'h0, 4'h0, 32'h12345678, 0, 0, lat);
    cmp("u1.known_cleared.err", 32'(w_errmm[1]), 32'd0);
    cmp("u1.txn_restart", 32'(w_txn[1]), 32'd1);

    repeat (3) @(posedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/dmem_shadow_monitor.md
Name: dmem_shadow_monitor

Overview:
Multi-entry shadow-memory monitor and wait-state responder for a core's unified valid/ready memory bus, used in formal and simulation harnesses. It drives mem_ready with a fixed, parametrised latency and shadows NTRACK tracked word addresses with per-byte "known" bits. It checks every data read against the shadow contents and raises sticky error flags on data mismatch or handshake-protocol violation.

Parameters:
AW, 32, address width
DW, 32, data width; multiple of 8; NB = DW/8 byte lanes
NTRACK, 2, number of tracked word addresses
WAIT_CYCLES, 0, wait cycles inserted before mem_ready; range 0..255
CHECK_INSTR, 0, when 1, instruction fetches (mem_instr=1) are also checked

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
mem_valid  in  1  request valid from core
mem_instr  in  1  request is an instruction fetch
mem_addr  in  AW  request byte address
mem_wdata  in  DW  write data
mem_wstrb  in  NB  byte write strobes; all-zero means read
mem_rdata  in  DW  read data returned by the memory model
track_addr  in  NTRACK*AW  tracked addresses, entry i in bits [i*AW +: AW]; static after reset
mem_ready  out  1  handshake completion
err_mismatch  out  1  sticky: read data disagreed with shadow on a known byte
mismatch_idx  out  clog2(NTRACK) (min 1)  entry index of the first mismatch
err_protocol  out  1  sticky: request dropped or changed before completion
txn_count  out  16  completed handshakes, saturating at 16'hFFFF

Behaviour:
- One clock; reset is asynchronous and active-high on port reset.
- Reset values: state=IDLE, mem_ready=0, wait counter=0, all known bits=0, shadow data=0, err_mismatch=0, mismatch_idx=0, err_protocol=0, txn_count=0. Reset mid-transaction abandons the transaction; no shadow update occurs.
- FSM states: IDLE, WAIT, ACK. mem_ready = (state==ACK). The output is registered-state decoded, with no combinational path from mem_valid.
- IDLE: when mem_valid=1, capture addr/wdata/wstrb/instr. If WAIT_CYCLES==0, go to ACK. Otherwise go to WAIT with cnt=WAIT_CYCLES-1.
- WAIT: if cnt==0, go to ACK; otherwise decrement cnt.
- Latency: mem_ready rises exactly WAIT_CYCLES+1 cycles after the first cycle mem_valid is seen high in IDLE.
- ACK: the handshake completes this cycle. Always return to IDLE next cycle. Back-to-back requests therefore have one idle bubble, and a request still valid in that cycle is treated as new.
- Protocol check, in WAIT and ACK: set err_protocol if mem_valid=0 or any of addr/wdata/wstrb/instr differs from the captured value. The handshake still completes normally; the captured values are used.
- Address match: entry i matches when mem_addr[AW-1:log2(NB)] == track_addr_i[AW-1:log2(NB)]. Low byte-offset bits are ignored. Several entries may match; each is processed independently.
- Write, ACK with wstrb!=0: for each matching entry and each lane b with wstrb[b]=1, set shadow byte = wdata byte and set known[b]=1.
- Read check, ACK with wstrb==0, and (mem_instr==0 or CHECK_INSTR==1): for each matching entry, compare rdata lanes whose known bit is 1. Unknown lanes are never flagged.
- On any differing known lane: set err_mismatch. If err_mismatch was previously 0, latch mismatch_idx = lowest mismatching entry index. Later mismatches do not change mismatch_idx.
- A read never modifies shadow state. Error flags clear only on reset.
- txn_count increments in every ACK cycle and holds at FFFF.
- Non-matching addresses: no shadow effect, no check; the handshake and txn_count still apply.

Test Plan:
- NTRACK=2, track={0x100,0x200}, WAIT=0: write 0x100 wdata=0xDEADBEEF wstrb=F, then read 0x100 rdata=0xDEADBEEF -> mem_ready one cycle after each valid, err_mismatch=0, txn_count=2.
- Same setup: read 0x100 with rdata=0xDEADBEEE -> err_mismatch=1 after the ACK cycle, mismatch_idx=0. A subsequent mismatch on 0x200 leaves mismatch_idx=0.
- Write 0x202 wstrb=4'b0011 wdata=0x0000ABCD, then read 0x200 rdata=0x1234ABCD -> no mismatch (upper lanes unknown). Repeat with rdata=0x1234ABCE -> mismatch_idx=1.
- WAIT_CYCLES=3: hold a valid read -> mem_ready high exactly on the 4th cycle after the valid is first seen, for one cycle. The next request's ready follows the bubble.
- WAIT_CYCLES=3: drop mem_valid in the 2nd wait cycle -> err_protocol=1, handshake still completes. Changing mem_addr mid-wait also sets err_protocol.
- Assert reset during WAIT after a write to 0x100 -> mem_ready=0, state IDLE, known bits cleared. A following read of 0x100 with any rdata gives no mismatch, and txn_count restarts at 0.
